obuf_loop_ctrl: RTL and testbench
=================================

Name: obuf_loop_ctrl

Overview:
Nested-loop sequencer for the output-buffer control path. It holds per-level iteration counts written by the instruction decoder, then walks the loop nest outermost-first. It drives the loop handshake consumed by the obuf bias/DDR-select logic: loop_enter, loop_exit, loop_index, loop_index_valid, loop_last_iter and loop_stall. One instance per obuf control path; it sits between the decoder and the obuf bias-select and address generators.

Parameters:
LOOP_ID_W, 5, width of loop level index; max nest depth 1<<LOOP_ID_W
LOOP_ITER_W, 16, width of per-level iteration count (stored as count-1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin walking the configured nest; sampled only in IDLE
cfg_loop_iter_v  in  1  append one loop level (outermost first); sampled only in IDLE
cfg_loop_iter  in  LOOP_ITER_W  iterations-1 for the appended level
stall  in  1  downstream backpressure; honoured only in STEP
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of nest
loop_index  out  LOOP_ID_W  current level (0 = outermost)
loop_enter  out  1  level loop_index entered this cycle
loop_exit  out  1  level loop_index exited this cycle
loop_index_valid  out  1  level loop_index iterates this cycle
loop_last_iter  out  1  current iteration of loop_index is its last
loop_stall  out  1  stall & (state==STEP)

Behaviour:
- Storage: iter_cfg[] and cnt[] arrays, one entry per level; num_loops register is LOOP_ID_W+1 bits; lvl register.
- Config (IDLE only): cfg_loop_iter_v writes iter_cfg[num_loops] and increments num_loops. Writes beyond 1<<LOOP_ID_W entries are dropped. num_loops clears in DONE and on reset.
- If cfg_loop_iter_v and start arrive in the same IDLE cycle, the write is included in the run.
- States: IDLE, ENTER, STEP, EXIT, DONE.
- IDLE: on start, go to ENTER with lvl=0. If num_loops==0, go to DONE instead.
- ENTER: loop_enter=1, loop_index=lvl, cnt[lvl]<=0. If lvl==num_loops-1, go to STEP; else lvl++ and stay in ENTER.
- STEP: loop_index=lvl, loop_last_iter=(cnt[lvl]==iter_cfg[lvl]), loop_index_valid=~stall. With stall asserted, all state is held.
  - On ~stall and last: go to EXIT.
  - On ~stall and not last: cnt[lvl]++. If lvl is innermost, stay in STEP; else lvl++ and go to ENTER.
- EXIT: loop_exit=1, loop_index=lvl. If lvl==0, go to DONE; else lvl-- and go to STEP (the parent's iteration).
- DONE: done=1 for one cycle, num_loops<=0, go to IDLE.
- Outputs are registered-state decodes (Moore). loop_enter, loop_exit and loop_index_valid are mutually exclusive.
- Reset values: all outputs 0, state IDLE, lvl 0, num_loops 0.
- In IDLE and DONE, loop_index is 0 and loop_last_iter is 0.
- start outside IDLE and cfg writes outside IDLE are ignored.
- Reset asserted mid-run aborts immediately: no done pulse, and configuration is lost.
- Counters compare with equality only; cnt never exceeds iter_cfg, so there is no wrap.
- An iter_cfg of 0 gives a single iteration, with loop_last_iter=1 on its only STEP.

Optional Feature:
OBUF_LOOP_CTRL_PERF_EN
- Defined: adds outputs perf_busy_cycles[31:0] and perf_stall_cycles[31:0].
  - Both clear on an accepted start.
  - perf_busy_cycles counts cycles with busy=1; perf_stall_cycles counts cycles with loop_stall=1.
  - Both saturate at all-ones and hold after done until the next start.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package obuf_loop_pkg holds:
  - state encodings ST_IDLE=0, ST_ENTER=1, ST_STEP=2, ST_EXIT=3, ST_DONE=4 (3-bit);
  - WR_DDR=0 and WR_PE=1, shared with the bias-select logic.
- One sub-module, obuf_loop_cfg_mem: iter_cfg storage with a single write port and an async read port indexed by lvl.

Test Plan:
- Single loop cfg=3, start at cycle 0, no stall -> enter@1; valid@2..5 with last only @5; exit@6; done@7; busy 1..7.
- Two loops cfg {1,2} -> enter count 3 (L0 once, L1 twice), exit count 3, valid count 8 (6 at L1, 2 at L0), L0 last only on its 2nd valid, done one cycle after the L0 exit.
- Same single loop with stall held high 3 cycles at the 2nd STEP -> loop_stall=1 and valid=0 for those 3 cycles, cnt held, done@10.
- start with no cfg -> done@1, no enter/exit/valid; cfg writes during busy ignored, and the next run uses only IDLE-time writes.
- Reset asserted during STEP of a 2-level run -> next cycle all outputs 0, state IDLE, no done; a following run with one fresh cfg=0 gives exactly one valid with last=1.
- With OBUF_LOOP_CTRL_PERF_EN, the stall run above -> perf_busy_cycles=10, perf_stall_cycles=3 after done.

Source files
------------

// File: rtl/obuf_loop_pkg.sv
// Shared encodings for the obuf loop sequencer and the bias/DDR-select logic.
package obuf_loop_pkg;

  typedef logic [2:0] loop_state_t;

  localparam loop_state_t ST_IDLE  = 3'd0;
  localparam loop_state_t ST_ENTER = 3'd1;
  localparam loop_state_t ST_STEP  = 3'd2;
  localparam loop_state_t ST_EXIT  = 3'd3;
  localparam loop_state_t ST_DONE  = 3'd4;

  localparam logic WR_DDR = 1'b0;
  localparam logic WR_PE  = 1'b1;

endpackage

// File: rtl/obuf_loop_ctrl_if.sv
// Loop handshake between the sequencer (master) and the obuf bias/address logic (slave).
interface obuf_loop_ctrl_if #(
  parameter int LOOP_ID_W = 5
);

  logic [LOOP_ID_W-1:0] loop_index;
  logic                 loop_enter;
  logic                 loop_exit;
  logic                 loop_index_valid;
  logic                 loop_last_iter;
  logic                 loop_stall;
  logic                 stall;

  modport master (
    output loop_index, loop_enter, loop_exit, loop_index_valid, loop_last_iter, loop_stall,
    input  stall
  );

  modport slave (
    input  loop_index, loop_enter, loop_exit, loop_index_valid, loop_last_iter, loop_stall,
    output stall
  );

endinterface

// File: rtl/obuf_loop_cfg_mem.sv
// Per-level iteration-count storage: one write port, async read indexed by the current level.
module obuf_loop_cfg_mem
  import obuf_loop_pkg::*;
#(
  parameter int LOOP_ID_W   = 5,
  parameter int LOOP_ITER_W = 16
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [LOOP_ID_W-1:0]   wr_addr,
  input  logic [LOOP_ITER_W-1:0] wr_data,
  input  logic [LOOP_ID_W-1:0]   rd_addr,
  output logic [LOOP_ITER_W-1:0] rd_data
);

  localparam int DEPTH = 1 << LOOP_ID_W;

  logic [LOOP_ITER_W-1:0] mem_r [DEPTH];

  // Store one level's count per accepted config write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/obuf_loop_ctrl.sv
// Nested-loop sequencer for the obuf control path; walks the configured nest outermost-first.
// Optional OBUF_LOOP_CTRL_PERF_EN adds busy/stall cycle counters.
module obuf_loop_ctrl
  import obuf_loop_pkg::*;
#(
  parameter int LOOP_ID_W   = 5,
  parameter int LOOP_ITER_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   cfg_loop_iter_v,
  input  logic [LOOP_ITER_W-1:0] cfg_loop_iter,
  output logic                   busy,
  output logic                   done,
`ifdef OBUF_LOOP_CTRL_PERF_EN
  output logic [31:0]            perf_busy_cycles,
  output logic [31:0]            perf_stall_cycles,
`endif
  obuf_loop_ctrl_if.master       lp
);

  localparam int DEPTH = 1 << LOOP_ID_W;
  localparam logic [LOOP_ID_W-1:0]   LVL_ONE = LOOP_ID_W'(1);
  localparam logic [LOOP_ID_W:0]     NL_ONE  = (LOOP_ID_W + 1)'(1);
  localparam logic [LOOP_ITER_W-1:0] CNT_ONE = LOOP_ITER_W'(1);

  loop_state_t            state_r;
  loop_state_t            state_nxt_s;
  logic [LOOP_ID_W-1:0]   lvl_r;
  logic [LOOP_ID_W:0]     num_loops_r;
  logic [LOOP_ITER_W-1:0] cnt_r [DEPTH];
  logic [LOOP_ITER_W-1:0] iter_cur_s;
  logic                   cfg_wr_s;
  logic                   is_inner_s;
  logic                   is_last_s;
  logic                   in_loop_s;

  // Writes past the last level are dropped by the full flag (num_loops MSB).
  assign cfg_wr_s   = (state_r == ST_IDLE) & cfg_loop_iter_v & ~num_loops_r[LOOP_ID_W];
  assign is_inner_s = ({1'b0, lvl_r} == (num_loops_r - NL_ONE));
  assign is_last_s  = (cnt_r[lvl_r] == iter_cur_s);
  assign in_loop_s  = (state_r == ST_ENTER) | (state_r == ST_STEP) | (state_r == ST_EXIT);

  obuf_loop_cfg_mem #(
    .LOOP_ID_W   (LOOP_ID_W),
    .LOOP_ITER_W (LOOP_ITER_W)
  ) u_cfg_mem (
    .clk     (clk),
    .wr_en   (cfg_wr_s),
    .wr_addr (num_loops_r[LOOP_ID_W-1:0]),
    .wr_data (cfg_loop_iter),
    .rd_addr (lvl_r),
    .rd_data (iter_cur_s)
  );

  // Next-state selection for the loop walk.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ((num_loops_r == '0) && !cfg_wr_s) ? ST_DONE : ST_ENTER;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ENTER: state_nxt_s = is_inner_s ? ST_STEP : ST_ENTER;
      ST_STEP: begin
        if (lp.stall) begin
          state_nxt_s = ST_STEP;
        end else if (is_last_s) begin
          state_nxt_s = ST_EXIT;
        end else begin
          state_nxt_s = is_inner_s ? ST_STEP : ST_ENTER;
        end
      end
      ST_EXIT: state_nxt_s = (lvl_r == '0) ? ST_DONE : ST_STEP;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, current level and configured depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      lvl_r       <= '0;
      num_loops_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          lvl_r <= '0;
          if (cfg_wr_s) begin
            num_loops_r <= num_loops_r + NL_ONE;
          end
        end
        ST_ENTER: begin
          if (!is_inner_s) begin
            lvl_r <= lvl_r + LVL_ONE;
          end
        end
        ST_STEP: begin
          if (!lp.stall && !is_last_s && !is_inner_s) begin
            lvl_r <= lvl_r + LVL_ONE;
          end
        end
        ST_EXIT: begin
          if (lvl_r != '0) begin
            lvl_r <= lvl_r - LVL_ONE;
          end
        end
        ST_DONE: num_loops_r <= '0;
        default: lvl_r <= '0;
      endcase
    end
  end

  // Iteration counters; each is zeroed on entry so no reset is needed.
  always_ff @(posedge clk) begin
    if (state_r == ST_ENTER) begin
      cnt_r[lvl_r] <= '0;
    end else if ((state_r == ST_STEP) && !lp.stall && !is_last_s) begin
      cnt_r[lvl_r] <= cnt_r[lvl_r] + CNT_ONE;
    end
  end

  assign busy                = (state_r != ST_IDLE);
  assign done                = (state_r == ST_DONE);
  assign lp.loop_index       = in_loop_s ? lvl_r : '0;
  assign lp.loop_enter       = (state_r == ST_ENTER);
  assign lp.loop_exit        = (state_r == ST_EXIT);
  assign lp.loop_index_valid = (state_r == ST_STEP) & ~lp.stall;
  assign lp.loop_last_iter   = (state_r == ST_STEP) & is_last_s;
  assign lp.loop_stall       = (state_r == ST_STEP) & lp.stall;

`ifdef OBUF_LOOP_CTRL_PERF_EN
  logic [31:0] perf_busy_r;
  logic [31:0] perf_stall_r;

  // Saturating busy/stall counters, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy_r  <= '0;
      perf_stall_r <= '0;
    end else if ((state_r == ST_IDLE) && start) begin
      perf_busy_r  <= '0;
      perf_stall_r <= '0;
    end else begin
      if (busy && (perf_busy_r != '1)) begin
        perf_busy_r <= perf_busy_r + 32'd1;
      end
      if (lp.loop_stall && (perf_stall_r != '1)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_busy_cycles  = perf_busy_r;
  assign perf_stall_cycles = perf_stall_r;
`endif

endmodule

// File: tb/tb_obuf_loop_ctrl.sv
// Directed self-checking bench for obuf_loop_ctrl; perf checks build with OBUF_LOOP_CTRL_PERF_EN.
module tb_obuf_loop_ctrl;

  localparam int IDW = 5;
  localparam int ITW = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           cfg_v;
  logic [ITW-1:0] cfg;
  logic           busy;
  logic           done;
`ifdef OBUF_LOOP_CTRL_PERF_EN
  logic [31:0]    perf_busy;
  logic [31:0]    perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  obuf_loop_ctrl_if #(.LOOP_ID_W(IDW)) lp_if ();

  obuf_loop_ctrl #(.LOOP_ID_W(IDW), .LOOP_ITER_W(ITW)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .cfg_loop_iter_v   (cfg_v),
    .cfg_loop_iter     (cfg),
    .busy              (busy),
    .done              (done),
`ifdef OBUF_LOOP_CTRL_PERF_EN
    .perf_busy_cycles  (perf_busy),
    .perf_stall_cycles (perf_stall),
`endif
    .lp                (lp_if)
  );

  always #5 clk = ~clk;

  // {busy, done, enter, exit, valid, last, loop_stall, index}
  function automatic logic [11:0] obs();
    return {busy, done, lp_if.loop_enter, lp_if.loop_exit, lp_if.loop_index_valid,
            lp_if.loop_last_iter, lp_if.loop_stall, lp_if.loop_index};
  endfunction

  function automatic logic [11:0] ev_en(input logic [4:0] i);
    return {7'b1010000, i};
  endfunction
  function automatic logic [11:0] ev_st(input logic [4:0] i, input logic last);
    return {5'b10001, last, 1'b0, i};
  endfunction
  function automatic logic [11:0] ev_ex(input logic [4:0] i);
    return {7'b1001000, i};
  endfunction
  localparam logic [11:0] EV_IDLE = 12'h000;
  localparam logic [11:0] EV_DONE = {7'b1100000, 5'd0};
  localparam logic [11:0] EV_HOLD = {7'b1000001, 5'd0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [ITW-1:0] val);
    cfg_v = 1'b1;
    cfg   = val;
    tick();
    cfg_v = 1'b0;
    cfg   = '0;
  endtask

  task automatic test_reset();
    logic [11:0] o;
    reset = 1'b1; start = 1'b0; cfg_v = 1'b0; cfg = '0; lp_if.stall = 1'b0;
    #1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    o = obs();
    checks++;
    if (o !== EV_IDLE) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", o, EV_IDLE);
    end
    tick();
  endtask

  task automatic test_single();
    logic [11:0] o, e;
    cfg_write(16'd3);
    for (int c = 0; c <= 8; c++) begin
      start = (c == 0);
      #1;
      case (c)
        1:       e = ev_en(5'd0);
        2, 3, 4: e = ev_st(5'd0, 1'b0);
        5:       e = ev_st(5'd0, 1'b1);
        6:       e = ev_ex(5'd0);
        7:       e = EV_DONE;
        default: e = EV_IDLE;
      endcase
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL single c%0d got %h exp %h", c, o, e);
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_two_level();
    logic [11:0] o, e;
    int n_en, n_ex, n_v, n_v0, n_v1;
    n_en = 0; n_ex = 0; n_v = 0; n_v0 = 0; n_v1 = 0;
    cfg_write(16'd1);
    cfg_write(16'd2);
    for (int c = 0; c <= 16; c++) begin
      start = (c == 0);
      #1;
      case (c)
        1:              e = ev_en(5'd0);
        2, 8:           e = ev_en(5'd1);
        3, 4, 9, 10:    e = ev_st(5'd1, 1'b0);
        5, 11:          e = ev_st(5'd1, 1'b1);
        6, 12:          e = ev_ex(5'd1);
        7:              e = ev_st(5'd0, 1'b0);
        13:             e = ev_st(5'd0, 1'b1);
        14:             e = ev_ex(5'd0);
        15:             e = EV_DONE;
        default:        e = EV_IDLE;
      endcase
      o = obs();
      if (lp_if.loop_enter) n_en++;
      if (lp_if.loop_exit) n_ex++;
      if (lp_if.loop_index_valid) begin
        n_v++;
        if (lp_if.loop_index == 5'd0) n_v0++;
        if (lp_if.loop_index == 5'd1) n_v1++;
      end
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL two_level c%0d got %h exp %h", c, o, e);
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (n_en !== 3 || n_ex !== 3) begin
      errors++;
      $display("FAIL two_level_enter_exit got %0d/%0d exp 3/3", n_en, n_ex);
    end
    checks++;
    if (n_v !== 8 || n_v0 !== 2 || n_v1 !== 6) begin
      errors++;
      $display("FAIL two_level_valid got %0d (L0 %0d L1 %0d) exp 8 (2 6)", n_v, n_v0, n_v1);
    end
  endtask

  task automatic test_stall();
    logic [11:0] o, e;
    cfg_write(16'd3);
    for (int c = 0; c <= 11; c++) begin
      start = (c == 0);
      // stall outside STEP (c1 ENTER, c9 EXIT) must have no effect
      lp_if.stall = (c == 1) || (c >= 3 && c <= 5) || (c == 9);
      #1;
      case (c)
        1:       e = ev_en(5'd0);
        2, 6, 7: e = ev_st(5'd0, 1'b0);
        3, 4, 5: e = EV_HOLD;
        8:       e = ev_st(5'd0, 1'b1);
        9:       e = ev_ex(5'd0);
        10:      e = EV_DONE;
        default: e = EV_IDLE;
      endcase
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stall c%0d got %h exp %h", c, o, e);
      end
      tick();
    end
    start = 1'b0;
    lp_if.stall = 1'b0;
`ifdef OBUF_LOOP_CTRL_PERF_EN
    #1;
    checks++;
    if (perf_busy !== 32'd10 || perf_stall !== 32'd3) begin
      errors++;
      $display("FAIL perf got busy %0d stall %0d exp 10 3", perf_busy, perf_stall);
    end
`endif
  endtask

  task automatic test_empty_and_busy_cfg();
    logic [11:0] o, e;
    // start with nothing configured
    for (int c = 0; c <= 2; c++) begin
      start = (c == 0);
      #1;
      e = (c == 1) ? EV_DONE : EV_IDLE;
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL empty c%0d got %h exp %h", c, o, e);
      end
      tick();
    end
    // cfg with start in the same cycle, then start/cfg held during the run
    for (int c = 0; c <= 6; c++) begin
      start = (c <= 4);
      cfg_v = (c <= 4);
      cfg   = (c == 0) ? 16'd0 : 16'd7;
      #1;
      case (c)
        1:       e = ev_en(5'd0);
        2:       e = ev_st(5'd0, 1'b1);
        3:       e = ev_ex(5'd0);
        4:       e = EV_DONE;
        default: e = EV_IDLE;
      endcase
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL busy_cfg c%0d got %h exp %h", c, o, e);
      end
      tick();
    end
    start = 1'b0; cfg_v = 1'b0; cfg = '0;
    cfg_write(16'd1);
    for (int c = 0; c <= 6; c++) begin
      start = (c == 0);
      #1;
      case (c)
        1:       e = ev_en(5'd0);
        2:       e = ev_st(5'd0, 1'b0);
        3:       e = ev_st(5'd0, 1'b1);
        4:       e = ev_ex(5'd0);
        5:       e = EV_DONE;
        default: e = EV_IDLE;
      endcase
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL after_busy_cfg c%0d got %h exp %h", c, o, e);
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [11:0] o, e;
    int n_v, n_l;
    cfg_write(16'd1);
    cfg_write(16'd2);
    for (int c = 0; c <= 7; c++) begin
      start = (c == 0);
      #1;
      case (c)
        1:       e = ev_en(5'd0);
        2:       e = ev_en(5'd1);
        3:       e = ev_st(5'd1, 1'b0);
        default: e = EV_IDLE;
      endcase
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid c%0d got %h exp %h", c, o, e);
      end
      reset = (c == 3);
      tick();
    end
    reset = 1'b0; start = 1'b0;
    n_v = 0; n_l = 0;
    cfg_write(16'd0);
    for (int c = 0; c <= 5; c++) begin
      start = (c == 0);
      #1;
      case (c)
        1:       e = ev_en(5'd0);
        2:       e = ev_st(5'd0, 1'b1);
        3:       e = ev_ex(5'd0);
        4:       e = EV_DONE;
        default: e = EV_IDLE;
      endcase
      o = obs();
      if (lp_if.loop_index_valid) n_v++;
      if (lp_if.loop_index_valid && lp_if.loop_last_iter) n_l++;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL post_reset c%0d got %h exp %h", c, o, e);
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (n_v !== 1 || n_l !== 1) begin
      errors++;
      $display("FAIL post_reset_valid got %0d/%0d exp 1/1", n_v, n_l);
    end
  endtask

  task automatic test_overflow();
    int n_en, n_v, n_l, done_c;
    n_en = 0; n_v = 0; n_l = 0; done_c = -1;
    // 33rd write must be dropped; its nonzero value would lengthen the walk
    for (int i = 0; i < 33; i++) begin
      cfg_write((i == 32) ? 16'd5 : 16'd0);
    end
    for (int c = 0; c <= 200 && done_c < 0; c++) begin
      start = (c == 0);
      #1;
      if (lp_if.loop_enter) n_en++;
      if (lp_if.loop_index_valid) n_v++;
      if (lp_if.loop_index_valid && lp_if.loop_last_iter) n_l++;
      if (done) done_c = c;
      tick();
    end
    start = 1'b0;
    checks++;
    if (done_c !== 97) begin
      errors++;
      $display("FAIL overflow_done got cycle %0d exp 97 (-1 means timeout)", done_c);
    end
    checks++;
    if (n_en !== 32 || n_v !== 32 || n_l !== 32) begin
      errors++;
      $display("FAIL overflow_counts got en %0d v %0d last %0d exp 32 32 32", n_en, n_v, n_l);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_level();
    test_stall();
    test_empty_and_busy_cfg();
    test_reset_mid_run();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
